// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32 control sequencer.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP = 3'd0,
        CLS_R   = 3'd1,
        CLS_I   = 3'd2,
        CLS_LW  = 3'd3,
        CLS_SW  = 3'd4,
        CLS_BEQ = 3'd5,
        CLS_JAL = 3'd6
    } cls_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Unknown opcodes fall into the NOP class.
    function automatic cls_t opcode_class(input logic [6:0] op);
        case (op)
            OP_R:    return CLS_R;
            OP_I:    return CLS_I;
            OP_LW:   return CLS_LW;
            OP_SW:   return CLS_SW;
            OP_BEQ:  return CLS_BEQ;
            OP_JAL:  return CLS_JAL;
            default: return CLS_NOP;
        endcase
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: opcode class, operand select and ALU op.
module mc_decode
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output cls_t       cls,
    output logic       alu_src,
    output logic [2:0] alu_op
);

    always_comb begin
        cls     = opcode_class(opcode);
        alu_src = 1'b0;
        alu_op  = ALU_ADD;
        case (cls)
            CLS_I, CLS_LW, CLS_SW: alu_src = 1'b1;
            default:               alu_src = 1'b0;
        endcase
        case (cls)
            CLS_BEQ: alu_op = ALU_SUB;
            CLS_R, CLS_I: begin
                case (funct3)
                    3'b000:  alu_op = (cls == CLS_R && funct7_b5) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    3'b010:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 sequencer owning pc/ir with req/ack memory handshakes.
// Optional perf counters are built when PERF_CNT_EN is defined.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned    XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned    WAIT_LIMIT   = 0,
    parameter int unsigned    CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             boot,
    input  logic [XLEN-1:0]  entry_point,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             zero,
    input  logic [XLEN-1:0]  branch_target,
    input  logic [XLEN-1:0]  jump_target,
    output logic [XLEN-1:0]  pc,
    output logic [31:0]      ir,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_write,
    output logic             alu_src,
    output logic             mem2reg,
    output logic [2:0]       alu_op,
    output logic             bus_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int unsigned WCNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    state_t            state, state_next;
    logic [XLEN-1:0]   pc_next, pc_plus4;
    logic [31:0]       ir_next;
    logic              bus_err_next;
    logic [WCNT_W-1:0] wait_cnt, wait_cnt_next;
    logic              waiting, timeout, retire;
    cls_t              cls;
    logic              dec_alu_src;
    logic [2:0]        dec_alu_op;

    mc_decode u_decode (
        .opcode    (ir[6:0]),
        .funct3    (ir[14:12]),
        .funct7_b5 (ir[30]),
        .cls       (cls),
        .alu_src   (dec_alu_src),
        .alu_op    (dec_alu_op)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pc       <= RESET_VECTOR;
            ir       <= '0;
            bus_err  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            ir       <= ir_next;
            bus_err  <= bus_err_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next state, pc/ir update, retire and ack-timeout detection.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        ir_next      = ir;
        bus_err_next = 1'b0;
        retire       = 1'b0;
        waiting      = 1'b0;
        pc_plus4     = pc + XLEN'(4);
        case (state)
            ST_IDLE: state_next = ST_IDLE;
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_next    = imem_rdata;
                    state_next = ST_DECODE;
                end else begin
                    waiting = 1'b1;
                end
            end
            ST_DECODE: state_next = ST_EXEC;
            ST_EXEC: begin
                case (cls)
                    CLS_BEQ: begin
                        pc_next    = zero ? branch_target : pc_plus4;
                        state_next = ST_FETCH;
                        retire     = 1'b1;
                    end
                    CLS_LW, CLS_SW:         state_next = ST_MEM;
                    CLS_R, CLS_I, CLS_JAL:  state_next = ST_WB;
                    default: begin
                        pc_next    = pc_plus4;
                        state_next = ST_FETCH;
                        retire     = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (cls == CLS_SW) begin
                        pc_next    = pc_plus4;
                        state_next = ST_FETCH;
                        retire     = 1'b1;
                    end else begin
                        state_next = ST_WB;
                    end
                end else begin
                    waiting = 1'b1;
                end
            end
            ST_WB: begin
                pc_next    = (cls == CLS_JAL) ? jump_target : pc_plus4;
                state_next = ST_FETCH;
                retire     = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase

        timeout       = (WAIT_LIMIT != 0) && waiting && (wait_cnt == WCNT_W'(WAIT_LIMIT - 1));
        wait_cnt_next = (waiting && !timeout) ? wait_cnt + WCNT_W'(1) : '0;
        if (timeout) begin
            state_next   = ST_IDLE;
            bus_err_next = 1'b1;
        end

        // boot overrides everything, including an ack or timeout this cycle.
        if (boot) begin
            state_next    = ST_FETCH;
            pc_next       = entry_point;
            ir_next       = ir;
            retire        = 1'b0;
            bus_err_next  = 1'b0;
            wait_cnt_next = '0;
        end
    end

    always_comb begin
        imem_req  = (state == ST_FETCH);
        dmem_req  = (state == ST_MEM);
        dmem_we   = (state == ST_MEM) && (cls == CLS_SW);
        reg_write = (state == ST_WB) && !boot;
        mem2reg   = (state == ST_WB) && (cls == CLS_LW);
        alu_src   = (state == ST_EXEC) && dec_alu_src;
        alu_op    = (state == ST_EXEC) ? dec_alu_op : ALU_AND;
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q, instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state != ST_IDLE) cycle_q <= cycle_q + CNT_W'(1);
            if (retire)           instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    logic unused_perf;
    assign unused_perf = retire;
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (WAIT_LIMIT=4 build).
module tb_multicycle_ctrl;
    import mc_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 32;

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_BEQ  = 32'h0020_8463;
    localparam logic [31:0] I_LW   = 32'h0000_A083;
    localparam logic [31:0] I_SW   = 32'h0020_A023;
    localparam logic [31:0] I_SUB  = 32'h4020_8033;
    localparam logic [31:0] I_JAL  = 32'h0000_006F;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             boot;
    logic [XLEN-1:0]  entry_point;
    logic [31:0]      imem_rdata;
    logic             imem_ack;
    logic             dmem_ack;
    logic             zero;
    logic [XLEN-1:0]  branch_target;
    logic [XLEN-1:0]  jump_target;
    logic [XLEN-1:0]  pc;
    logic [31:0]      ir;
    logic             imem_req, dmem_req, dmem_we, reg_write, alu_src, mem2reg, bus_err;
    logic [2:0]       alu_op;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    multicycle_ctrl #(
        .XLEN(XLEN), .RESET_VECTOR('0), .WAIT_LIMIT(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .boot(boot), .entry_point(entry_point),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .zero(zero), .branch_target(branch_target), .jump_target(jump_target),
        .pc(pc), .ir(ir), .imem_req(imem_req), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .reg_write(reg_write), .alu_src(alu_src),
        .mem2reg(mem2reg), .alu_op(alu_op), .bus_err(bus_err),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction with a same-cycle ack; returns in DECODE.
    task automatic fetch(input logic [31:0] w);
        imem_rdata = w;
        imem_ack   = 1'b1;
        tick();
        imem_ack   = 1'b0;
    endtask

    function automatic logic [63:0] perf(input int v);
`ifdef PERF_CNT_EN
        return 64'(v);
`else
        return 64'(v * 0);
`endif
    endfunction

    initial begin
        rst_n = 1'b0; boot = 1'b0; entry_point = '0; imem_rdata = '0;
        imem_ack = 1'b0; dmem_ack = 1'b0; zero = 1'b0;
        branch_target = '0; jump_target = '0;

        // Reset state
        repeat (2) tick();
        check("rst_state", 64'(dut.state), 64'(ST_IDLE));
        check("rst_pc", 64'(pc), 64'h0);
        check("rst_ir", 64'(ir), 64'h0);
        check("rst_outs", 64'({imem_req, dmem_req, dmem_we, reg_write, alu_src, mem2reg, bus_err, alu_op}), 64'h0);
        check("rst_cnt", 64'(cycle_cnt | instret_cnt), 64'h0);
        rst_n = 1'b1;
        tick();
        check("idle_hold", 64'(dut.state), 64'(ST_IDLE));

        // 1: boot to 0x28, addi with zero-wait fetch
        boot = 1'b1; entry_point = 32'h28;
        tick();
        boot = 1'b0;
        check("t1_fetch_pc", 64'(pc), 64'h28);
        check("t1_imem_req", 64'(imem_req), 64'h1);
        fetch(I_ADDI);
        check("t1_ir", 64'(ir), 64'(I_ADDI));
        check("t1_dec_state", 64'(dut.state), 64'(ST_DECODE));
        tick();
        check("t1_exec_alu", 64'({alu_src, alu_op}), 64'({1'b1, ALU_ADD}));
        tick();
        check("t1_wb_regwrite", 64'({reg_write, mem2reg}), 64'b10);
        tick();
        check("t1_pc", 64'(pc), 64'h2C);
        check("t1_after_wb", 64'({reg_write, dut.state}), 64'({1'b0, ST_FETCH}));

        // 2: beq taken and not taken
        fetch(I_BEQ);
        tick();
        zero = 1'b1; branch_target = 32'h40;
        check("t2_exec_sub", 64'({alu_src, alu_op}), 64'({1'b0, ALU_SUB}));
        tick();
        check("t2_taken_pc", 64'(pc), 64'h40);
        fetch(I_BEQ);
        tick();
        zero = 1'b0;
        tick();
        check("t2_nottaken_pc", 64'(pc), 64'h44);

        // 3: lw with dmem_ack three cycles late
        fetch(I_LW);
        tick();
        check("t3_exec_alu", 64'({alu_src, alu_op}), 64'({1'b1, ALU_ADD}));
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3_dmem_req%0d", k), 64'({dmem_req, dmem_we}), 64'b10);
            if (k == 3) dmem_ack = 1'b1;
            tick();
        end
        dmem_ack = 1'b0;
        check("t3_wb", 64'({reg_write, mem2reg}), 64'b11);
        tick();
        check("t3_pc", 64'(pc), 64'h48);

        // 4: imem_ack never arrives
        repeat (3) tick();
        check("t4_still_fetch", 64'({bus_err, dut.state}), 64'({1'b0, ST_FETCH}));
        tick();
        check("t4_bus_err", 64'({bus_err, dut.state}), 64'({1'b1, ST_IDLE}));
        check("t4_pc_held", 64'(pc), 64'h48);
        tick();
        check("t4_pulse_end", 64'({bus_err, dut.state}), 64'({1'b0, ST_IDLE}));

        // R-type sub and jal
        boot = 1'b1; entry_point = 32'h100;
        tick();
        boot = 1'b0;
        fetch(I_SUB);
        tick();
        check("r_sub_alu", 64'({alu_src, alu_op}), 64'({1'b0, ALU_SUB}));
        repeat (2) tick();
        check("r_pc", 64'(pc), 64'h104);
        jump_target = 32'h80;
        fetch(I_JAL);
        repeat (3) tick();
        check("jal_pc", 64'(pc), 64'h80);

        // 5: boot during MEM of sw, alone and together with dmem_ack
        fetch(I_SW);
        repeat (2) tick();
        check("t5_sw_mem", 64'({dmem_req, dmem_we}), 64'b11);
        tick();
        boot = 1'b1; entry_point = 32'h200;
        tick();
        boot = 1'b0;
        check("t5_boot_pc", 64'({dut.state, pc}), 64'({ST_FETCH, 32'h200}));
        fetch(I_SW);
        repeat (2) tick();
        boot = 1'b1; dmem_ack = 1'b1; entry_point = 32'h300;
        tick();
        boot = 1'b0; dmem_ack = 1'b0;
        check("t5_boot_beats_ack", 64'({dut.state, pc}), 64'({ST_FETCH, 32'h300}));
        fetch(I_ADDI);
        repeat (2) tick();
        boot = 1'b1; entry_point = 32'h400;
        #1;
        check("t5_wb_abort_regwrite", 64'(reg_write), 64'h0);
        tick();
        boot = 1'b0;
        check("t5_wb_abort_pc", 64'(pc), 64'h400);
        check("t5_instret", 64'(instret_cnt), perf(6));

        // 6: counters over ten zero-wait addi
        rst_n = 1'b0;
        #1;
        check("t6_async_rst", 64'({dut.state, cycle_cnt}), 64'({ST_IDLE, 32'h0}));
        tick();
        rst_n = 1'b1;
        boot = 1'b1; entry_point = '0;
        tick();
        boot = 1'b0;
        imem_rdata = I_ADDI; imem_ack = 1'b1;
        repeat (40) tick();
        imem_ack = 1'b0;
        check("t6_pc", 64'(pc), 64'h28);
        check("t6_instret", 64'(instret_cnt), perf(10));
        check("t6_cycle", 64'(cycle_cnt), perf(40));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
